// File: rtl/debug_text_pkg.sv
// Shared constants and types for the debug text overlay.
package debug_text_pkg;

  localparam int FONT_ROWS = 16;
  localparam int FONT_COLS = 8;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Row where vertical blanking starts; the displayed value may only change here.
  localparam logic [9:0] FRAME_TICK_ROW = 10'd480;

  typedef logic [7:0] glyph_code_t;

endpackage

// File: rtl/bcd_digit_overlay_if.sv
// Valid/ready handshake carrying a packed BCD number (nibble 0 = least significant).
interface bcd_digit_overlay_if #(
  parameter int NUM_DIGITS = 3
) ();

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    bcd_valid;
  logic                    bcd_ready;

  modport master (output bcd_in, output bcd_valid, input bcd_ready);
  modport slave  (input bcd_in, input bcd_valid, output bcd_ready);

endinterface

// File: rtl/font_rom.sv
// 8x16 glyph ROM, combinational read. Only the glyphs the digit overlay can
// emit (space, '0'..'9', '?') are populated; every other code reads as blank.
// Address is {code[6:0], row}; row 0 is the top scanline, bit 7 the leftmost pixel.
module font_rom (
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);

  localparam logic [127:0] G_ZERO  = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
  localparam logic [127:0] G_ONE   = 128'h00001838781818181818187E00000000;
  localparam logic [127:0] G_TWO   = 128'h00007CC6060C183060C0C6FE00000000;
  localparam logic [127:0] G_THREE = 128'h00007CC606063C060606C67C00000000;
  localparam logic [127:0] G_FOUR  = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
  localparam logic [127:0] G_FIVE  = 128'h0000FEC0C0C0FC060606C67C00000000;
  localparam logic [127:0] G_SIX   = 128'h00003860C0C0FCC6C6C6C67C00000000;
  localparam logic [127:0] G_SEVEN = 128'h0000FEC606060C183030303000000000;
  localparam logic [127:0] G_EIGHT = 128'h00007CC6C6C67CC6C6C6C67C00000000;
  localparam logic [127:0] G_NINE  = 128'h00007CC6C6C67E0606060C7800000000;
  localparam logic [127:0] G_QMARK = 128'h00007CC6C60C18181800181800000000;

  logic [127:0] bitmap;
  logic [3:0]   row;

  assign row = addr_i[3:0];

  // Select the glyph bitmap for the code part of the address.
  always_comb begin
    bitmap = '0;
    case (addr_i[10:4])
      7'h30:   bitmap = G_ZERO;
      7'h31:   bitmap = G_ONE;
      7'h32:   bitmap = G_TWO;
      7'h33:   bitmap = G_THREE;
      7'h34:   bitmap = G_FOUR;
      7'h35:   bitmap = G_FIVE;
      7'h36:   bitmap = G_SIX;
      7'h37:   bitmap = G_SEVEN;
      7'h38:   bitmap = G_EIGHT;
      7'h39:   bitmap = G_NINE;
      7'h3F:   bitmap = G_QMARK;
      default: bitmap = '0;
    endcase
  end

  // Row 0 sits in the most-significant byte, so invert the row to get the byte offset.
  assign data_o = bitmap[{~row, 3'b000} +: 8];

endmodule

// File: rtl/bcd_digit_overlay.sv
// Renders a BCD number as 8x16 glyphs at a fixed screen position. New values
// are accepted into a one-deep pending slot and promoted to the displayed
// value only at the start of vertical blanking, so a frame never tears.
module bcd_digit_overlay
  import debug_text_pkg::*;
#(
  parameter logic [9:0] X_POS      = 10'd0,
  parameter logic [9:0] Y_POS      = 10'd0,
  parameter int         NUM_DIGITS = 3,
  parameter bit         LEAD_BLANK = 1'b1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  bcd_digit_overlay_if.slave  bcd,
  output logic                pixel_on
);

  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0] pending_q, pending_d;
  logic         pending_full_q, pending_full_d;
  logic [W-1:0] display_q, display_d;
  logic [9:0]   drawy_prev_q;

  logic         in_box_q, in_box_d;
  logic [2:0]   col_q, col_d;
  logic [10:0]  font_addr_q, font_addr_d;
  logic         pixel_on_q;

  logic         frame_tick;
  logic         xfer;
  logic [7:0]   font_data;

  glyph_code_t  codes [NUM_DIGITS];
  glyph_code_t  sel_code;
  logic [9:0]   rel_x;
  logic [6:0]   char_idx;
  logic [3:0]   row_d;
  logic [10:0]  x_ext, x_lo, x_hi, y_ext, y_lo, y_hi;

  assign frame_tick    = (DrawY == FRAME_TICK_ROW) && (drawy_prev_q != FRAME_TICK_ROW);
  assign bcd.bcd_ready = !pending_full_q;
  assign xfer          = bcd.bcd_valid && !pending_full_q;

  // Pending/display next state. A tick and a transfer cannot both touch the
  // full flag: a transfer needs the slot empty, a drain needs it full.
  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    display_d      = display_q;
    if (frame_tick && pending_full_q) begin
      display_d      = pending_q;
      pending_full_d = 1'b0;
    end
    if (xfer) begin
      pending_d      = bcd.bcd_in;
      pending_full_d = 1'b1;
    end
  end

  // Handshake, display and frame-tick history registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      display_q      <= '0;
      drawy_prev_q   <= '0;
    end else begin
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      display_q      <= display_d;
      drawy_prev_q   <= DrawY;
    end
  end

  // Digit-to-glyph mapping, most-significant digit first so leading zeros
  // can be blanked; any non-zero nibble (including non-BCD) ends blanking.
  always_comb begin
    logic       blanking;
    logic [3:0] nib;
    blanking = LEAD_BLANK;
    nib      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) codes[i] = ASCII_SPACE;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = display_q[4*i +: 4];
      if (blanking && (nib == 4'd0) && (i != 0)) begin
        codes[i] = ASCII_SPACE;
      end else begin
        blanking = 1'b0;
        codes[i] = (nib <= 4'd9) ? (ASCII_ZERO + {4'd0, nib}) : ASCII_QMARK;
      end
    end
  end

  // Box test in 11 bits so a box reaching past column 1023 does not wrap.
  always_comb begin
    x_ext    = {1'b0, DrawX};
    x_lo     = {1'b0, X_POS};
    x_hi     = x_lo + 11'(FONT_COLS * NUM_DIGITS);
    y_ext    = {1'b0, DrawY};
    y_lo     = {1'b0, Y_POS};
    y_hi     = y_lo + 11'(FONT_ROWS);
    in_box_d = (x_ext >= x_lo) && (x_ext < x_hi) && (y_ext >= y_lo) && (y_ext < y_hi);
    rel_x    = DrawX - X_POS;
    col_d    = rel_x[2:0];
    char_idx = rel_x[9:3];
    row_d    = DrawY[3:0] - Y_POS[3:0];
  end

  // Character index 0 is the leftmost, most-significant digit.
  always_comb begin
    sel_code = ASCII_SPACE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (char_idx == 7'(NUM_DIGITS - 1 - i)) sel_code = codes[i];
    end
    font_addr_d = 11'({sel_code, row_d});
  end

  // Stage 1: box flag, column and font address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_box_q    <= 1'b0;
      col_q       <= '0;
      font_addr_q <= '0;
    end else begin
      in_box_q    <= in_box_d;
      col_q       <= col_d;
      font_addr_q <= font_addr_d;
    end
  end

  font_rom u_font_rom (
    .addr_i (font_addr_q),
    .data_o (font_data)
  );

  // Stage 2: pick the glyph bit for this column, masked outside the box.
  always_ff @(posedge Clk) begin
    if (Reset) pixel_on_q <= 1'b0;
    else       pixel_on_q <= in_box_q && font_data[3'd7 - col_q];
  end

  assign pixel_on = pixel_on_q;

endmodule

// File: doc/bcd_digit_overlay.md
# bcd_digit_overlay

Display-side consumer of decimal debug digits: accepts a packed BCD number over a valid/ready handshake, holds it stable for one whole video frame, and renders it as 8x16 font glyphs at a fixed screen position. It sits between the debug digit producers and the VGA colour mapper, and drives a one-bit `pixel_on` overlay aligned to the DrawX/DrawY raster.

## Interface
Parameters:
- `X_POS`, 10'd0, left pixel column of the text box.
- `Y_POS`, 10'd0, top pixel row of the text box.
- `NUM_DIGITS`, 3, number of decimal digits rendered (1..8).
- `LEAD_BLANK`, 1, when 1, leading zeros render as blank; the least-significant digit always renders.

Ports:
- `Clk`  in  1  system clock. Single clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `DrawX`  in  10  current raster column.
- `DrawY`  in  10  current raster row.
- `bcd_in`  in  4*NUM_DIGITS  packed BCD value. Nibble 0 is the least-significant digit.
- `bcd_valid`  in  1  producer offers `bcd_in`.
- `bcd_ready`  out  1  pending slot is empty.
- `pixel_on`  out  1  text foreground at the raster position presented 2 cycles earlier.

## Operation
- Two registers: `pending` (value plus full flag) and `display` (value shown).
- Handshake: `bcd_ready = !pending_full`. A transfer occurs when `bcd_valid && bcd_ready`, and then `pending <= bcd_in` and `pending_full <= 1`. `bcd_in` is ignored when `bcd_ready` is low.
- Frame tick:
  - Asserted for one cycle on the first cycle in which `DrawY == 480` and the previous cycle's `DrawY != 480`.
  - On the tick, if `pending_full` is set, `display <= pending` and `pending_full <= 0`.
- Simultaneous tick and transfer:
  - This can only occur with `pending` empty.
  - `pending` captures the new value.
  - `display` is unchanged; there is no bypass.
- Glyph code per digit:
  - Nibble 0..9 maps to `ASCII_ZERO` + nibble.
  - Nibble 10..15 maps to `ASCII_QMARK`.
  - A blanked leading zero maps to `ASCII_SPACE`.
  - A non-BCD nibble ends leading-zero blanking.
- Box test:
  - `X_POS <= DrawX < X_POS + 8*NUM_DIGITS` and `Y_POS <= DrawY < Y_POS + 16`.
  - Compare in 11 bits so a box edge past 1023 does not wrap.
- Within the box:
  - col = (DrawX - X_POS)[2:0].
  - row = (DrawY - Y_POS)[3:0].
  - Char index = (DrawX - X_POS) >> 3. Index 0 is the leftmost and most-significant digit.
- Font address (11 bits) = code*16 + row. The bit shown is `font_data[7 - col]`.
- Outside the box, `pixel_on = 0`.

## Timing
- Reset values:
  - `pixel_on = 0`, `bcd_ready = 1`, `pending_full = 0`, `pending = 0`.
  - `display = 0`, which renders as "  0" when `LEAD_BLANK = 1`.
  - Previous-`DrawY` register = 0, so no spurious tick occurs after reset.
- Reset mid-frame or mid-handshake: all state returns to the reset values in the same cycle, and a pending value is lost.
- Pixel pipeline:
  - Stage 1 registers in-box, col, row and the font address.
  - Stage 2 registers `pixel_on` from the combinational font ROM data.
  - Total latency is exactly 2 `Clk` cycles from `DrawX`/`DrawY` to `pixel_on`. The pipeline does not stall.
- `display` changes only on a frame tick, i.e. during vertical blanking, so a frame never shows a torn value.
- `bcd_ready` falls the cycle after an accepted transfer. It rises the cycle after a frame tick that drains `pending`.
- One update per frame at most; the producer is throttled by `bcd_ready`.

## Structure
- Package `debug_text_pkg` holds:
  - `FONT_ROWS = 16`, `FONT_COLS = 8`.
  - `ASCII_ZERO = 8'h30`, `ASCII_QMARK = 8'h3F`, `ASCII_SPACE = 8'h20`.
  - `FRAME_TICK_ROW = 10'd480`.
  - Typedef `glyph_code_t` (`logic [7:0]`).
- Sub-module: one `font_rom` instance (existing, 11-bit addr, 8-bit data, combinational read).
- Digit-to-glyph mapping and leading-blank logic stay in this module as an `always_comb`.

## Test plan
- Reset release with `X_POS = 0`, `Y_POS = 0`, defaults, then raster row 5 -> glyph pixels appear only in columns 16..23 and match the '0' glyph row 5; `bcd_ready = 1`.
- Send `bcd_in = 12'h640` during row 100 -> `bcd_ready` falls next cycle; the frame still shows "  0"; at `DrawY = 480`, `bcd_ready` rises; the next frame shows "640".
- Send `12'h007` -> renders "  7" with columns 0..15 blank; the same value with `LEAD_BLANK = 0` renders "007".
- Send `12'h1A5` -> renders "1?5".
- Tick and transfer in the same cycle with `pending` empty -> `display` is unchanged this frame; the value appears after the following tick.
- Assert `Reset` during row 200 with `pending` full -> next cycle `pixel_on = 0`, `bcd_ready = 1`; the next frame shows "  0".
- Step `DrawX` across the box edge `X_POS + 24` -> `pixel_on` drops exactly 2 cycles after `DrawX` reaches the edge.
